// File: rtl/iic_slave_pkg.sv
// Shared constants for the I2C EEPROM responder: FSM encodings, bus levels, device type.
package iic_slave_pkg;

   localparam logic [3:0] DEV_TYPE_DEF = 4'b1010;

   localparam logic ACK         = 1'b0;
   localparam logic NACK        = 1'b1;
   localparam logic SDA_RELEASE = 1'b1;

   typedef logic [3:0] state_t;

   localparam state_t IDLE      = 4'd0;
   localparam state_t DEV_ADDR  = 4'd1;
   localparam state_t DEV_ACK   = 4'd2;
   localparam state_t WORD_ADDR = 4'd3;
   localparam state_t WORD_ACK  = 4'd4;
   localparam state_t WR_DATA   = 4'd5;
   localparam state_t WR_ACK    = 4'd6;
   localparam state_t RD_DATA   = 4'd7;
   localparam state_t RD_ACK    = 4'd8;

   function automatic logic dev_match(input logic [7:0] rx, input logic [3:0] dev_type,
                                      input logic [2:0] straps);
      return rx[7:1] == {dev_type, straps};
   endfunction

endpackage

// File: rtl/iic_line_sync.sv
// Synchronizes scl/sda into clk and flags scl edges plus START/STOP conditions.
// Pulses are one clk wide, three clk after the pin change.
module iic_line_sync (
   input  logic clk,
   input  logic reset_,
   input  logic scl,
   input  logic sda_i,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic scl_m, scl_s, scl_d;
   logic sda_m, sda_s, sda_d;

   // Idle bus is high, so reset the chain high to avoid a false edge after reset.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         scl_m <= 1'b1;
         scl_s <= 1'b1;
         scl_d <= 1'b1;
         sda_m <= 1'b1;
         sda_s <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_m <= scl;
         scl_s <= scl_m;
         scl_d <= scl_s;
         sda_m <= sda_i;
         sda_s <= sda_m;
         sda_d <= sda_s;
      end
   end

   assign sda      = sda_s;
   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;
   assign start    = scl_s & scl_d & sda_d & ~sda_s;
   assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/iic_eeprom_slave.sv
// 24C02-style I2C EEPROM target: 8-bit word address, page-wrapped writes, sequential reads.
// sda_o only moves on a detected scl fall, except START/STOP which release it at once.
module iic_eeprom_slave
   import iic_slave_pkg::*;
#(
   parameter logic [3:0] DEV_TYPE  = DEV_TYPE_DEF,
   parameter int         ADDR_W    = 8,
   parameter int         MEM_DEPTH = 256,
   parameter int         PAGE_SIZE = 8
) (
   input  logic clk,
   input  logic reset_,
   input  logic scl,
   input  logic sda_i,
   output logic sda_o,
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic wp,
   output logic busy
);

   localparam int PG_W = $clog2(PAGE_SIZE);

   logic              sda, scl_rise, scl_fall, start, stop;
   state_t            state;
   logic [2:0]        bit_cnt;
   logic [6:0]        shift;
   logic [ADDR_W-1:0] addr;
   logic              rw;
   logic [7:0]        mem [MEM_DEPTH];
   logic [7:0]        rx_byte;
   logic [7:0]        rd_byte;
   logic              wr_en;

   iic_line_sync u_sync (
      .clk      (clk),
      .reset_   (reset_),
      .scl      (scl),
      .sda_i    (sda_i),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   assign rx_byte = {shift, sda};
   assign rd_byte = mem[addr];
   assign wr_en   = scl_rise && !start && !stop && (state == WR_DATA) && (bit_cnt == 3'd7) && !wp;

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= rx_byte;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state   <= IDLE;
         sda_o   <= SDA_RELEASE;
         busy    <= 1'b0;
         addr    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         rw      <= 1'b0;
      end else if (start) begin
         state   <= DEV_ADDR;
         bit_cnt <= '0;
         sda_o   <= SDA_RELEASE;
         busy    <= 1'b0;
      end else if (stop) begin
         state <= IDLE;
         sda_o <= SDA_RELEASE;
         busy  <= 1'b0;
      end else if (scl_rise) begin
         case (state)
            DEV_ADDR, WORD_ADDR, WR_DATA: begin
               shift   <= rx_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (state == DEV_ADDR) begin
                     rw <= sda;
                     if (dev_match(rx_byte, DEV_TYPE, {a2, a1, a0})) begin
                        state <= DEV_ACK;
                        busy  <= 1'b1;
                     end else begin
                        state <= IDLE;
                     end
                  end else if (state == WORD_ADDR) begin
                     addr  <= rx_byte[ADDR_W-1:0];
                     state <= WORD_ACK;
                  end else if (!wp) begin
                     // Page write: only the in-page offset advances.
                     addr[PG_W-1:0] <= addr[PG_W-1:0] + PG_W'(1);
                     state          <= WR_ACK;
                  end else begin
                     sda_o <= NACK;
                     state <= IDLE;
                  end
               end
            end
            RD_DATA: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  addr  <= addr + ADDR_W'(1);
                  state <= RD_ACK;
               end
            end
            RD_ACK: state <= (sda == ACK) ? RD_DATA : IDLE;
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state)
            // First fall in an ACK state drives the ACK, the second ends it.
            DEV_ACK, WORD_ACK, WR_ACK: begin
               if (sda_o == SDA_RELEASE) begin
                  sda_o <= ACK;
               end else if (state == DEV_ACK && rw) begin
                  sda_o <= rd_byte[7];
                  state <= RD_DATA;
               end else begin
                  sda_o <= SDA_RELEASE;
                  state <= (state == DEV_ACK) ? WORD_ADDR : WR_DATA;
               end
            end
            RD_DATA: sda_o <= rd_byte[3'd7 - bit_cnt];
            default: sda_o <= SDA_RELEASE;
         endcase
      end
   end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench: bit-banged I2C master driving write/read vectors against the EEPROM target.
module tb_iic_eeprom_slave;

   localparam time Q = 50ns;

   logic clk = 1'b0;
   logic reset_ = 1'b0;
   logic scl = 1'b1;
   logic sda_m = 1'b1;
   logic sda_o;
   logic a0 = 1'b1, a1 = 1'b0, a2 = 1'b1;
   logic wp = 1'b0;
   logic busy;

   int n_vec = 0;
   int n_err = 0;

   logic       mon_en = 1'b0;
   logic       saw_low = 1'b0;
   logic [7:0] rd_buf [4];

   typedef struct {
      logic [7:0] waddr;
      logic [7:0] wdata;
      logic       wp;
      logic       exp_dack;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vt [8];

   iic_eeprom_slave dut (
      .clk    (clk),
      .reset_ (reset_),
      .scl    (scl),
      .sda_i  (sda_m),
      .sda_o  (sda_o),
      .a0     (a0),
      .a1     (a1),
      .a2     (a2),
      .wp     (wp),
      .busy   (busy)
   );

   always #5ns clk = ~clk;

   always @(negedge clk) if (mon_en && !sda_o) saw_low = 1'b1;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #Q;
      scl = 1'b1;   #Q;
      sda_m = 1'b0; #Q;
      scl = 1'b0;   #Q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #Q;
      scl = 1'b1;   #Q;
      sda_m = 1'b1; #Q;
   endtask

   task automatic put_bit(input logic b);
      sda_m = b; #Q;
      scl = 1'b1; #(2*Q);
      scl = 1'b0; #Q;
   endtask

   task automatic get_bit(output logic b);
      sda_m = 1'b1; #Q;
      scl = 1'b1;   #Q;
      b = sda_o;    #Q;
      scl = 1'b0;   #Q;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(ack);
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) get_bit(d[i]);
      put_bit(mack);
   endtask

   // Random read of n bytes starting at a; all acks are checked, data lands in rd_buf.
   task automatic rand_read(input string tag, input logic [7:0] a, input int n);
      logic ack;
      i2c_start();
      send_byte(8'hAA, ack); check({tag, " rd dev ack"}, {7'd0, ack}, 8'h00);
      send_byte(a, ack);     check({tag, " rd word ack"}, {7'd0, ack}, 8'h00);
      i2c_start();
      send_byte(8'hAB, ack); check({tag, " rd devr ack"}, {7'd0, ack}, 8'h00);
      for (int i = 0; i < n; i++) recv_byte(i == n - 1, rd_buf[i]);
      check({tag, " rd release"}, {7'd0, sda_o}, 8'h01);
      i2c_stop();
   endtask

   initial begin
      logic ack;
      vt[0] = '{8'h10, 8'h5C, 1'b0, 1'b0, 8'h5C};
      vt[1] = '{8'h40, 8'h77, 1'b0, 1'b0, 8'h77};
      vt[2] = '{8'h40, 8'h33, 1'b1, 1'b1, 8'h77};
      vt[3] = '{8'h00, 8'hA5, 1'b0, 1'b0, 8'hA5};
      vt[4] = '{8'hFF, 8'h3C, 1'b0, 1'b0, 8'h3C};
      vt[5] = '{8'h20, 8'h99, 1'b0, 1'b0, 8'h99};
      vt[6] = '{8'h01, 8'h5A, 1'b0, 1'b0, 8'h5A};
      vt[7] = '{8'hFE, 8'hC3, 1'b0, 1'b0, 8'hC3};

      #23ns;
      check("reset sda_o", {7'd0, sda_o}, 8'h01);
      check("reset busy", {7'd0, busy}, 8'h00);
      @(negedge clk);
      reset_ = 1'b1;
      #(4*Q);

      for (int v = 0; v < 8; v++) begin
         wp = vt[v].wp;
         i2c_start();
         send_byte(8'hAA, ack); check($sformatf("v%0d dev ack", v), {7'd0, ack}, 8'h00);
         check($sformatf("v%0d busy", v), {7'd0, busy}, 8'h01);
         send_byte(vt[v].waddr, ack); check($sformatf("v%0d word ack", v), {7'd0, ack}, 8'h00);
         send_byte(vt[v].wdata, ack);
         check($sformatf("v%0d data ack", v), {7'd0, ack}, {7'd0, vt[v].exp_dack});
         i2c_stop();
         #30ns;
         check($sformatf("v%0d busy after stop", v), {7'd0, busy}, 8'h00);
         wp = 1'b0;
         #(2*Q);
         rand_read($sformatf("v%0d", v), vt[v].waddr, 1);
         check($sformatf("v%0d read data", v), rd_buf[0], vt[v].exp_rd);
         #(2*Q);
      end

      // Sequential read across the top of the array.
      rand_read("seq", 8'hFE, 4);
      check("seq FE", rd_buf[0], 8'hC3);
      check("seq FF", rd_buf[1], 8'h3C);
      check("seq 00", rd_buf[2], 8'hA5);
      check("seq 01", rd_buf[3], 8'h5A);
      #(2*Q);

      // Page write starting two bytes before the page end.
      i2c_start();
      send_byte(8'hAA, ack); check("pg dev ack", {7'd0, ack}, 8'h00);
      send_byte(8'h1E, ack); check("pg word ack", {7'd0, ack}, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         send_byte(8'(i), ack);
         check($sformatf("pg data%0d ack", i), {7'd0, ack}, 8'h00);
      end
      i2c_stop();
      #(2*Q);
      rand_read("pg1E", 8'h1E, 2);
      check("pg mem1E", rd_buf[0], 8'h01);
      check("pg mem1F", rd_buf[1], 8'h02);
      rand_read("pg18", 8'h18, 2);
      check("pg mem18", rd_buf[0], 8'h03);
      check("pg mem19", rd_buf[1], 8'h04);
      rand_read("pg20", 8'h20, 1);
      check("pg mem20", rd_buf[0], 8'h99);
      #(2*Q);

      // Wrong device address: never driven low, never busy.
      i2c_start();
      saw_low = 1'b0;
      mon_en = 1'b1;
      send_byte(8'hA0, ack);
      mon_en = 1'b0;
      check("mismatch ack", {7'd0, ack}, 8'h01);
      check("mismatch sda low", {7'd0, saw_low}, 8'h00);
      check("mismatch busy", {7'd0, busy}, 8'h00);
      i2c_stop();
      #(2*Q);

      // Reset while the slave drives bit 7 (0) of 0x5C.
      i2c_start();
      send_byte(8'hAA, ack);
      send_byte(8'h10, ack);
      i2c_start();
      send_byte(8'hAB, ack);
      check("rst pre sda", {7'd0, sda_o}, 8'h00);
      reset_ = 1'b0;
      #1ns;
      check("rst sda release", {7'd0, sda_o}, 8'h01);
      check("rst busy", {7'd0, busy}, 8'h00);
      sda_m = 1'b1;
      scl = 1'b1;
      @(negedge clk);
      reset_ = 1'b1;
      #(4*Q);
      rand_read("post rst", 8'h10, 1);
      check("post rst data", rd_buf[0], 8'h5C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
